// File: rtl/strength_resolve_net.sv
// strength_resolve_net: resolves NUM_DRV strength-tagged drivers onto one WIDTH-bit
// net using wired-net strength rules. Two register stages: stage 1 holds the
// per-bit max0/max1 strengths, stage 2 resolves them and optionally keeps trireg charge.
module strength_resolve_net #(
   parameter int NUM_DRV      = 4,
   parameter int WIDTH        = 8,
   parameter int TRIREG       = 0,
   parameter int DECAY_CYCLES = 16,
   parameter int CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [NUM_DRV*WIDTH-1:0] drv_val,
   input  logic [NUM_DRV*WIDTH-1:0] drv_en,
   input  logic [NUM_DRV*3-1:0]     drv_str0,
   input  logic [NUM_DRV*3-1:0]     drv_str1,
   input  logic                     cnt_clr,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_val,
   output logic [WIDTH-1:0]         out_x,
   output logic [WIDTH-1:0]         out_z,
   output logic [CNT_W-1:0]         conflict_cnt
);

   localparam int DW = (DECAY_CYCLES > 0) ? $clog2(DECAY_CYCLES + 1) : 1;

   logic [2:0]              vld_pipe;
   logic [WIDTH-1:0][2:0]   max0_d, max1_d, max0_q, max1_q;
   logic [WIDTH-1:0]        res_x_v;
   logic                    any_x;
   logic [CNT_W-1:0]        cnt_q;

   assign vld_pipe[0] = in_valid;

   // Strongest 0 and strongest 1 seen on each bit; a released or strength-0 driver adds nothing
   always_comb begin
      max0_d = '0;
      max1_d = '0;
      for (int b = 0; b < WIDTH; b++) begin
         for (int d = 0; d < NUM_DRV; d++) begin
            if (drv_en[d*WIDTH+b]) begin
               if (drv_val[d*WIDTH+b]) begin
                  if (drv_str1[d*3 +: 3] > max1_d[b]) max1_d[b] = drv_str1[d*3 +: 3];
               end else begin
                  if (drv_str0[d*3 +: 3] > max0_d[b]) max0_d[b] = drv_str0[d*3 +: 3];
               end
            end
         end
      end
   end

   // Stage 1 strength capture plus the valid shift register for both stages
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe[2:1] <= '0;
         max0_q        <= '0;
         max1_q        <= '0;
      end else begin
         vld_pipe[2:1] <= vld_pipe[1:0];
         if (in_valid) begin
            max0_q <= max0_d;
            max1_q <= max1_d;
         end
      end
   end

   genvar b;
   generate
      for (b = 0; b < WIDTH; b++) begin : gen_bit
         logic          res_z, res_0, res_1, res_x;
         logic          chg_q, chg_d, chgv_q, chgv_d, dead_q, dead_d;
         logic [DW-1:0] dcnt_q, dcnt_d;
         logic          oval_q, oval_d, ox_q, ox_d, oz_q, oz_d;

         assign res_z      = (max0_q[b] == 3'd0) && (max1_q[b] == 3'd0);
         assign res_1      = max1_q[b] > max0_q[b];
         assign res_0      = max0_q[b] > max1_q[b];
         assign res_x      = !res_z && (max0_q[b] == max1_q[b]);
         assign res_x_v[b] = res_x;

         // Resolution plus charge bookkeeping; decay ticks every clock, a valid result then overrides it
         always_comb begin
            chg_d  = chg_q;
            chgv_d = chgv_q;
            dead_d = dead_q;
            dcnt_d = dcnt_q;
            oval_d = oval_q;
            ox_d   = ox_q;
            oz_d   = oz_q;
            if (TRIREG != 0 && DECAY_CYCLES != 0 && chg_q && dcnt_q != '0) begin
               dcnt_d = dcnt_q - DW'(1);
               if (dcnt_q == DW'(1)) begin
                  chg_d  = 1'b0;
                  dead_d = 1'b1;
               end
            end
            if (vld_pipe[1]) begin
               if (res_0 || res_1) begin
                  oval_d = res_1;
                  ox_d   = 1'b0;
                  oz_d   = 1'b0;
                  if (TRIREG != 0) begin
                     chg_d  = 1'b1;
                     chgv_d = res_1;
                     dead_d = 1'b0;
                     dcnt_d = DW'(DECAY_CYCLES);
                  end
               end else if (res_x) begin
                  oval_d = 1'b0;
                  ox_d   = 1'b1;
                  oz_d   = 1'b0;
                  chg_d  = 1'b0;
                  dead_d = 1'b0;
                  dcnt_d = '0;
               end else if (chg_d) begin
                  // undriven but charge still alive: show the stored level
                  oval_d = chgv_q;
                  ox_d   = 1'b0;
                  oz_d   = 1'b0;
               end else if (dead_d) begin
                  // charge decayed away: unknown until redriven
                  oval_d = 1'b0;
                  ox_d   = 1'b1;
                  oz_d   = 1'b0;
               end else begin
                  oval_d = 1'b0;
                  ox_d   = 1'b0;
                  oz_d   = 1'b1;
               end
            end
         end

         // Stage 2 output and charge registers
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               chg_q  <= 1'b0;
               chgv_q <= 1'b0;
               dead_q <= 1'b0;
               dcnt_q <= '0;
               oval_q <= 1'b0;
               ox_q   <= 1'b0;
               oz_q   <= 1'b1;
            end else begin
               chg_q  <= chg_d;
               chgv_q <= chgv_d;
               dead_q <= dead_d;
               dcnt_q <= dcnt_d;
               oval_q <= oval_d;
               ox_q   <= ox_d;
               oz_q   <= oz_d;
            end
         end

         assign out_val[b] = oval_q;
         assign out_x[b]   = ox_q;
         assign out_z[b]   = oz_q;
      end
   endgenerate

   // One count per valid sample with any contention bit, never per bit
   assign any_x = vld_pipe[1] && (|res_x_v);

   // Saturating contention counter; a clear that coincides with an increment lands on 1
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= any_x ? CNT_W'(1) : '0;
      end else if (any_x && !(&cnt_q)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_valid    = vld_pipe[2];
   assign conflict_cnt = cnt_q;

endmodule

// File: doc/strength_resolve_net.md
Name: strength_resolve_net

Overview:
- Parametrised multi-driver net resolver for the signal-strength feature set.
- Combines NUM_DRV drivers, each carrying its own strength0/strength1 pair, into one resolved WIDTH-bit net per IEEE 1800 wired-net strength rules.
- Registered two-stage pipeline with optional trireg-style charge retention and decay.
- Counts contention cycles so benches can check strength conflicts without relying on simulator strength support.

Parameters:
- NUM_DRV, 4: number of drivers, 1..8.
- WIDTH, 8: bits per net.
- TRIREG, 0: 0 = wire semantics; 1 = undriven bits hold the last driven value.
- DECAY_CYCLES, 16: cycles a held charge survives before becoming X; 0 = hold forever (TRIREG=1 only).
- CNT_W, 16: conflict counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  driver sample valid.
- drv_val  in  NUM_DRV*WIDTH  driver values; driver d occupies bits [d*WIDTH +: WIDTH].
- drv_en  in  NUM_DRV*WIDTH  per-bit enable; 0 = driver releases that bit.
- drv_str0  in  NUM_DRV*3  strength when driving 0, per driver.
- drv_str1  in  NUM_DRV*3  strength when driving 1, per driver.
- cnt_clr  in  1  clears conflict_cnt.
- out_valid  out  1  resolved sample valid.
- out_val  out  WIDTH  resolved value; 0 when X or Z.
- out_x  out  WIDTH  resolved bit is unknown.
- out_z  out  WIDTH  resolved bit is high impedance.
- conflict_cnt  out  CNT_W  saturating count of valid samples with any contention X.

Behaviour:
- Strength codes: 0 highz, 1 small, 2 medium, 3 weak, 4 large, 5 pull, 6 strong, 7 supply.
- Per bit and driver:
  - if drv_en=1 and drv_val=1, the driver contributes drv_str1 to max1;
  - if drv_en=1 and drv_val=0, the driver contributes drv_str0 to max0;
  - if drv_en=0, the driver contributes 0.
- Stage 1: register max0/max1 (3 bits each, per bit) and in_valid.
- Stage 2 resolution:
  - max0=max1=0 gives Z.
  - max1>max0 gives 1.
  - max0>max1 gives 0.
  - max0=max1≠0 gives X (contention).
- Latency: in_valid on cycle N gives out_valid and its result on cycle N+2. Back-to-back samples every cycle. No backpressure.
- Outputs and charge state update only on valid stage-2 samples. They hold between valid samples.
- Exactly one of {driven, out_x, out_z} holds per bit. out_val=0 whenever out_x or out_z is 1.
- TRIREG=1:
  - A Z result on a bit with stored charge outputs the stored value (out_z=0).
  - A per-bit decay counter starts at DECAY_CYCLES when the bit goes undriven. It decrements every clock, including cycles without valid samples.
  - When the counter reaches 0, the bit outputs X and the charge is discarded.
  - A driven 0 or 1 result stores new charge and reloads the counter.
  - Contention X discards the charge.
- TRIREG=0: Z passes through and no charge is kept.
- conflict_cnt:
  - Increments by 1 per valid stage-2 sample with at least one contention bit, not per bit.
  - Saturates at all-ones.
  - Decay-generated X does not count.
  - If cnt_clr and an increment occur in the same cycle, the result is 1. cnt_clr alone gives 0.
- Reset is synchronous active-low and applies on the first edge with rst_n=0, including mid-pipeline: in-flight samples are dropped. Reset values:
  - out_valid=0, out_val=0, out_x=0, out_z=all ones, conflict_cnt=0.
  - All charge invalid, decay counters 0, pipeline valids 0.
- A strength-0 driver with drv_en=1 behaves as released.

Test Plan:
- Wire mode, NUM_DRV=2, WIDTH=8. Driver0 = 0xFF with (strong0, strong1). Driver1 = 0x00 with (pull0, pull1). All enabled. -> 2 cycles later: out_val=0xFF, out_x=0, out_z=0, conflict_cnt unchanged.
- Driver0 = 0xFF with str1=pull. Driver1 = 0x00 with str0=pull. All enabled. -> out_x=0xFF, out_val=0; conflict_cnt increments by exactly 1 per valid sample; 3 samples -> 3.
- All drv_en=0 in wire mode -> out_z=0xFF. Then 0x0F on bits [3:0] only -> out_val=0x0F, out_z=0xF0.
- TRIREG=1, DECAY_CYCLES=4. Drive 0xA5, then release all bits with in_valid held high. -> out_val=0xA5 for 4 cycles, then out_x=0xFF. Redriving 0x3C restores out_val=0x3C.
- cnt_clr asserted in the same cycle as a contention sample -> conflict_cnt=1. With CNT_W=2, 5 contention samples -> saturates at 3.
- rst_n low for 1 cycle while a contention sample is in stage 1 -> next cycle out_valid=0, out_z=0xFF, conflict_cnt=0; no late increment from the dropped sample.
